// File: rtl/uart_pkg.sv
// ============================================================================
//  Module   : uart_pkg
//  Brief    : Shared types and divisor helpers for the UART transmit path.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

    // Rounded clocks-per-bit, e.g. 50 MHz / 115200 -> 434.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    localparam int DEFAULT_DIV = calc_div(50_000_000, 115200);
    localparam int BAUD_CNT_W  = $clog2(DEFAULT_DIV);

endpackage

`default_nettype wire

// File: rtl/uart_tx_ctrl_if.sv
// ============================================================================
//  Module   : uart_tx_ctrl_if
//  Brief    : Valid/ready byte stream feeding the UART transmitter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface uart_tx_ctrl_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
//  Module   : uart_tx_fifo
//  Brief    : Small synchronous first-word-fall-through FIFO for TX bytes.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic                       clk_50MHz,
    input  wire logic                       arst,
    input  wire logic                       push,
    input  wire logic                       pop,
    input  wire logic [WIDTH-1:0]           wdata,
    output logic      [WIDTH-1:0]           rdata,
    output logic                            full,
    output logic                            empty,
    output logic      [$clog2(DEPTH):0]     level
);
    import uart_pkg::*;

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_LVL = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Storage is left unreset; only pointers define valid contents.
    always_ff @(posedge clk_50MHz) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk_50MHz or posedge arst) begin
        if (arst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rdata = r_mem[r_rd_ptr];
    assign full  = (r_count == FULL_LVL);
    assign empty = (r_count == '0);
    assign level = r_count;

endmodule

`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
// ============================================================================
//  Module   : uart_tx_ctrl
//  Brief    : UART transmitter: TX FIFO, baud counter and framing FSM.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic                          clk_50MHz,
    input  wire logic                          arst,
    uart_tx_ctrl_if.slave                      tx,
    output logic                               uart_txd,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_level
);
    localparam int DIV    = calc_div(CLK_HZ, BAUD);
    localparam int DIV_M1 = DIV - 1;
    localparam int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W  = 3;
    localparam int DATA_M1 = DATA_BITS - 1;
    localparam int STOP_M1 = STOP_BITS - 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = DIV_M1[CNT_W-1:0];
    localparam logic [IDX_W-1:0] DATA_LAST = DATA_M1[IDX_W-1:0];
    localparam logic [IDX_W-1:0] STOP_LAST = STOP_M1[IDX_W-1:0];

    uart_tx_state_t        r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_parity;
    logic                  r_txd;
    logic                  r_busy;

    logic [DATA_BITS-1:0]  w_head;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_bit_end;
    logic                  w_frame_end;

    assign tx.tx_ready = !w_full;
    assign w_push      = tx.tx_valid && !w_full;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_50MHz (clk_50MHz),
        .arst      (arst),
        .push      (w_push),
        .pop       (w_pop),
        .wdata     (tx.tx_data),
        .rdata     (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .level     (fifo_level)
    );

    assign w_bit_end   = (r_cnt == CNT_LAST);
    assign w_frame_end = (r_state == STOP) && w_bit_end && (r_idx == STOP_LAST);
    // Popping on the last stop cycle chains frames with no idle gap.
    assign w_pop       = !w_empty && ((r_state == IDLE) || w_frame_end);

    always_ff @(posedge clk_50MHz or posedge arst) begin
        if (arst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_txd    <= 1'b1;
            r_busy   <= 1'b0;
        end else if (w_pop) begin
            r_state  <= START;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= w_head;
            r_parity <= (PARITY_ODD != 0) ? ~^w_head : ^w_head;
            r_txd    <= 1'b0;
            r_busy   <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt  <= '0;
                    r_txd  <= 1'b1;
                    r_busy <= 1'b0;
                end
                START: begin
                    if (w_bit_end) begin
                        r_state <= DATA;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_txd   <= r_shift[0];
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_idx == DATA_LAST) begin
                            r_idx <= '0;
                            if (PARITY_EN != 0) begin
                                r_state <= PARITY;
                                r_txd   <= r_parity;
                            end else begin
                                r_state <= STOP;
                                r_txd   <= 1'b1;
                            end
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_shift <= r_shift >> 1;
                            r_txd   <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (w_bit_end) begin
                        r_state <= STOP;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_txd   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_idx == STOP_LAST) begin
                            r_state <= IDLE;
                            r_idx   <= '0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_txd   <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign uart_txd = r_txd;
    assign busy     = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
// ============================================================================
//  Module   : tb_uart_tx_ctrl
//  Brief    : Directed self-checking bench for uart_tx_ctrl in four configs.
//  Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx_ctrl;

    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic [7:0] data  [4];
    logic       valid [4];
    logic       ready [4];
    logic       txd   [4];
    logic       bsy   [4];
    logic [2:0] lvl   [4];

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // u0: 115200 8N1, u1: DIV=10 8N1, u2: DIV=10 8E2, u3: DIV=10 8O1
    uart_tx_ctrl_if #(.DATA_BITS(8)) if0 ();
    uart_tx_ctrl_if #(.DATA_BITS(8)) if1 ();
    uart_tx_ctrl_if #(.DATA_BITS(8)) if2 ();
    uart_tx_ctrl_if #(.DATA_BITS(8)) if3 ();

    assign if0.tx_data = data[0];  assign if0.tx_valid = valid[0];  assign ready[0] = if0.tx_ready;
    assign if1.tx_data = data[1];  assign if1.tx_valid = valid[1];  assign ready[1] = if1.tx_ready;
    assign if2.tx_data = data[2];  assign if2.tx_valid = valid[2];  assign ready[2] = if2.tx_ready;
    assign if3.tx_data = data[3];  assign if3.tx_valid = valid[3];  assign ready[3] = if3.tx_ready;

    uart_tx_ctrl u0 (
        .clk_50MHz (clk), .arst (arst), .tx (if0),
        .uart_txd (txd[0]), .busy (bsy[0]), .fifo_level (lvl[0])
    );
    uart_tx_ctrl #(.BAUD(5_000_000)) u1 (
        .clk_50MHz (clk), .arst (arst), .tx (if1),
        .uart_txd (txd[1]), .busy (bsy[1]), .fifo_level (lvl[1])
    );
    uart_tx_ctrl #(.BAUD(5_000_000), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u2 (
        .clk_50MHz (clk), .arst (arst), .tx (if2),
        .uart_txd (txd[2]), .busy (bsy[2]), .fifo_level (lvl[2])
    );
    uart_tx_ctrl #(.BAUD(5_000_000), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u3 (
        .clk_50MHz (clk), .arst (arst), .tx (if3),
        .uart_txd (txd[3]), .busy (bsy[3]), .fifo_level (lvl[3])
    );

    // Line log: entry i holds the state after the i-th edge following start_log.
    logic log_en = 1'b0;
    int   log_u  = 0;
    logic log_txd  [$];
    logic log_busy [$];
    bit   exp_q    [$];

    always @(negedge clk) begin
        if (log_en) begin
            log_txd.push_back(txd[log_u]);
            log_busy.push_back(bsy[log_u]);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_log(input int u);
        log_txd.delete();
        log_busy.delete();
        log_u  = u;
        log_en = 1'b1;
    endtask

    task automatic push_byte(input int u, input logic [7:0] d);
        data[u]  = d;
        valid[u] = 1'b1;
        step(1);
        valid[u] = 1'b0;
    endtask

    task automatic add_frame(input logic [7:0] d, input int par_en, input int par_odd, input int stops);
        bit p;
        exp_q.push_back(1'b0);
        p = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(d[i]);
            p = p ^ d[i];
        end
        if (par_en != 0) exp_q.push_back(par_odd != 0 ? ~p : p);
        for (int i = 0; i < stops; i++) exp_q.push_back(1'b1);
    endtask

    // Each expected bit must hold for exactly div logged cycles from offset off.
    task automatic check_log(input string tag, input int off, input int div);
        for (int j = 0; j < exp_q.size(); j++) begin
            int mism;
            mism = 0;
            for (int c = 0; c < div; c++) begin
                int idx;
                idx = off + j * div + c;
                if (idx >= log_txd.size()) mism++;
                else if (log_txd[idx] !== exp_q[j]) mism++;
            end
            check_val($sformatf("%s_bit%0d", tag, j), mism, 0);
        end
    endtask

    function automatic int busy_count();
        int n = 0;
        foreach (log_busy[i]) if (log_busy[i] === 1'b1) n++;
        return n;
    endfunction

    function automatic int low_count();
        int n = 0;
        foreach (log_txd[i]) if (log_txd[i] !== 1'b1) n++;
        return n;
    endfunction

    function automatic logic log_at(input int idx);
        if (idx >= log_txd.size()) return 1'bx;
        return log_txd[idx];
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc [6];
        for (int u = 0; u < 4; u++) begin
            data[u]  = 8'h00;
            valid[u] = 1'b0;
        end
        step(3);
        arst = 1'b0;
        step(1);

        for (int u = 0; u < 4; u++) begin
            check_val($sformatf("rst_txd_u%0d", u),   txd[u],   1);
            check_val($sformatf("rst_busy_u%0d", u),  bsy[u],   0);
            check_val($sformatf("rst_level_u%0d", u), lvl[u],   0);
            check_val($sformatf("rst_ready_u%0d", u), ready[u], 1);
        end

        // Default 8N1 at 434 cycles per bit.
        start_log(0);
        push_byte(0, 8'h55);
        step(4400);
        log_en = 1'b0;
        exp_q.delete();
        add_frame(8'h55, 0, 0, 1);
        check_val("def_latency_txd", log_at(1), 1);
        check_log("def_frame", 2, 434);
        check_val("def_busy_cycles", busy_count(), 4340);
        check_val("def_idle_after", log_at(4342), 1);

        // DIV=10 8N1 single byte.
        start_log(1);
        push_byte(1, 8'h55);
        step(120);
        log_en = 1'b0;
        exp_q.delete();
        add_frame(8'h55, 0, 0, 1);
        check_val("d10_latency_txd", log_at(1), 1);
        check_val("d10_start_edge", log_at(2), 0);
        check_log("d10_frame", 2, 10);
        check_val("d10_busy_cycles", busy_count(), 100);

        // Six bytes with tx_valid held: FIFO fills, sixth waits for a pop.
        start_log(1);
        for (int k = 0; k < 6; k++) begin
            int waited;
            data[1]  = k[7:0];
            valid[1] = 1'b1;
            waited   = 0;
            while (!ready[1] && waited < 400) begin
                step(1);
                waited++;
            end
            check_val($sformatf("burst_ready_%0d", k), ready[1], 1);
            acc[k] = cyc + 1;
            step(1);
            if (k == 4) begin
                check_val("burst_full_ready", ready[1], 0);
                check_val("burst_full_level", lvl[1], 4);
            end
        end
        valid[1] = 1'b0;
        step(640);
        log_en = 1'b0;
        check_val("burst_5th_accept", acc[4] - acc[0], 4);
        check_val("burst_6th_accept", acc[5] - acc[0], 102);
        exp_q.delete();
        for (int k = 0; k < 6; k++) add_frame(k[7:0], 0, 0, 1);
        check_log("burst", 2, 10);
        check_val("burst_busy_cycles", busy_count(), 600);
        check_val("burst_idle_after", log_at(602), 1);

        // Even parity, two stop bits.
        start_log(2);
        push_byte(2, 8'h07);
        step(130);
        log_en = 1'b0;
        exp_q.delete();
        add_frame(8'h07, 1, 0, 2);
        check_log("even2", 2, 10);
        check_val("even_parity_bit", log_at(97), 1);
        check_val("even2_busy_cycles", busy_count(), 120);
        check_val("even2_stop_high", log_at(102) & log_at(112) & log_at(121), 1);

        // Odd parity, one stop bit.
        start_log(3);
        push_byte(3, 8'h07);
        step(120);
        log_en = 1'b0;
        exp_q.delete();
        add_frame(8'h07, 1, 1, 1);
        check_log("odd1", 2, 10);
        check_val("odd_parity_bit", log_at(97), 0);
        check_val("odd1_busy_cycles", busy_count(), 110);

        // Asynchronous reset in the middle of data bit 3 of 0xA5.
        push_byte(1, 8'hA5);
        push_byte(1, 8'h11);
        push_byte(1, 8'h22);
        step(43);
        check_val("pre_rst_bit3", txd[1], 0);
        check_val("pre_rst_level", lvl[1], 2);
        arst = 1'b1;
        #1;
        check_val("rst_mid_txd", txd[1], 1);
        check_val("rst_mid_busy", bsy[1], 0);
        check_val("rst_mid_level", lvl[1], 0);
        step(2);
        arst = 1'b0;
        start_log(1);
        step(200);
        log_en = 1'b0;
        check_val("post_rst_low_cycles", low_count(), 0);
        check_val("post_rst_busy_cycles", busy_count(), 0);

        // Push attempt while full must be dropped.
        start_log(1);
        for (int k = 0; k < 5; k++) push_byte(1, 8'h10 + k[7:0]);
        check_val("full_level", lvl[1], 4);
        check_val("full_ready", ready[1], 0);
        push_byte(1, 8'hFF);
        check_val("full_ignore_level", lvl[1], 4);
        step(520);
        log_en = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 5; k++) add_frame(8'h10 + k[7:0], 0, 0, 1);
        check_log("full", 2, 10);
        check_val("full_busy_cycles", busy_count(), 500);
        check_val("full_idle_after", log_at(502), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- UART transmitter that drives the board `uart_txd` pin from a valid/ready byte stream.
- Complements the existing `uart_rxd` input path.
- Contains a small synchronous FIFO, a baud-rate tick generator and a framing FSM.
- Frame options: start bit, DATA_BITS data bits LSB-first, optional parity, 1 or 2 stop bits. Frames are emitted back-to-back while the FIFO is non-empty.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency in Hz.
- BAUD, 115200, line rate; DIV = (CLK_HZ + BAUD/2) / BAUD clock cycles per bit (434 at defaults).
- DATA_BITS, 8, data bits per frame (5..8).
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
- STOP_BITS, 1, number of stop bits (1 or 2).
- FIFO_DEPTH, 4, entries in the TX FIFO (power of two, >= 2).

Ports:
- clk_50MHz  input  1  system clock.
- arst  input  1  asynchronous reset, active-high.
- tx_data  input  DATA_BITS  byte to transmit.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  FIFO can accept data (= !full).
- uart_txd  output  1  serial line, idle high, registered.
- busy  output  1  frame in progress, or FIFO non-empty.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values (asynchronous): uart_txd=1, busy=0, fifo_level=0, tx_ready=1, FSM=IDLE, baud counter=0, FIFO pointers=0.
- Push: a byte is written on a clock edge where tx_valid && tx_ready. tx_valid while tx_ready=0 is ignored; the producer must hold the data.
- Simultaneous push and pop leave fifo_level unchanged. A push while full is impossible because tx_ready=0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: on the first edge where the FIFO is non-empty, pop the head, load the shift register, compute parity, set uart_txd=0 and go to START.
  - Latency: a byte pushed into an empty FIFO at edge N drives the start bit from edge N+1.
- Every state holds its bit for exactly DIV cycles. The baud counter counts 0..DIV-1, is reloaded on each state/bit change, and does not free-run in IDLE.
- START -> DATA.
- DATA: drive shift[0], shift right each bit period; after DATA_BITS bits go to PARITY if PARITY_EN, else STOP.
- PARITY: drive ^data for even parity, ~^data for odd parity; then go to STOP.
- STOP: drive 1 for STOP_BITS*DIV cycles.
  - On the final cycle, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Frame length = DIV * (1 + DATA_BITS + PARITY_EN + STOP_BITS) cycles.
- busy = (state != IDLE) || (fifo_level != 0), registered.
- uart_txd comes from a flop only, with no combinational path from inputs.
- Reset mid-frame: uart_txd returns to 1 immediately, the FIFO is cleared and the frame is aborted. Nothing resumes after release.

Decomposition:
- Package uart_pkg:
  - `uart_tx_state_t` enum {IDLE, START, DATA, PARITY, STOP}.
  - Function `calc_div(clk_hz, baud)` returning the rounded divisor.
  - Localparam for baud counter width, $clog2(DIV).
- Sub-module uart_tx_fifo: synchronous FIFO with parameters WIDTH and DEPTH.
  - Ports: push, pop, wdata, rdata (head, first-word-fall-through), full, empty, level.
  - Same clock and async reset as the parent.
- FSM and baud counter live in uart_tx_ctrl.

Test Plan:
- Defaults, push 0x55: measure the start-bit low time -> exactly 434 cycles; full 8N1 frame 4340 cycles.
- BAUD=5_000_000 (DIV=10), push 0x55:
  - txd low 10 cycles, then data bits 1,0,1,0,1,0,1,0 at 10 cycles each, stop bit high 10 cycles.
  - busy high exactly 100 cycles.
  - Start bit begins one edge after the push.
- DIV=10, tx_valid held for 6 consecutive bytes 0x00..0x05:
  - tx_ready drops after the 5th accept; the 6th is taken after the first frame's pop slot.
  - Six frames back-to-back, 600 cycles, no high gap between stop and start.
- DIV=10, PARITY_EN=1, push 0x07:
  - even parity -> parity bit 1; PARITY_ODD=1 -> 0.
  - With STOP_BITS=2, frame = 120 cycles and the line is high for the final 20.
- DIV=10, assert arst during data bit 3 of 0xA5 with 2 bytes queued:
  - uart_txd=1 in the same cycle; busy=0 and fifo_level=0 immediately.
  - After release, txd stays high for 200 cycles.
- Push with tx_ready=0 (FIFO full, data 0xFF):
  - fifo_level stays at 4 and 0xFF is never transmitted unless tx_valid is held until accepted.
